// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
//   Forwarding and load-use hazard control for a 5-stage MIPS pipeline,
//   located in the ID stage. Shadows the destination info of the
//   instructions in EX and MEM and derives, every cycle:
//     - forward selects for operand A (rs) and operand B (rt)
//         00 register file, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
//     - PC/IF-ID write enable (wpcir, 0 = stall) and bubble-insert strobe
//     - a saturating count of load-use stall cycles
//
// Ports
//   clk        pipeline clock, rising-edge state updates
//   clrn       asynchronous active-low reset
//   id_rs/rt   source registers of the ID instruction
//   id_use_rs/rt  ID instruction actually reads rs / rt
//   id_wreg    ID instruction writes the register file
//   id_m2reg   ID instruction is a load
//   id_rn      destination register of the ID instruction
//   flush      ID instruction squashed by a taken branch/jump
//   freeze     global hold; all state holds
//   fwda/fwdb  operand A / B forward selects
//   wpcir      PC / IF-ID write enable
//   bubble     EX receives a NOP this cycle
//   stall_cnt  saturating load-use stall cycle counter

module fwd_hazard_ctrl #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [RA_W-1:0]  id_rn,
  input  logic             flush,
  input  logic             freeze,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  // Shadow copies of the EX and MEM destination info
  logic            ex_wreg, ex_m2reg;
  logic [RA_W-1:0] ex_rn;
  logic            mm_wreg, mm_m2reg;
  logic [RA_W-1:0] mm_rn;

  logic exm_a, mmm_a, exm_b, mmm_b;
  logic haz_a, haz_b, stall;

  always_comb begin
    exm_a = id_use_rs & ex_wreg & (ex_rn == id_rs) & (id_rs != '0);
    mmm_a = id_use_rs & mm_wreg & (mm_rn == id_rs) & (id_rs != '0);
    exm_b = id_use_rt & ex_wreg & (ex_rn == id_rt) & (id_rt != '0);
    mmm_b = id_use_rt & mm_wreg & (mm_rn == id_rt) & (id_rt != '0);

    // A load still in EX has no data yet: select falls back to 00 and stall
    haz_a = exm_a & ex_m2reg;
    haz_b = exm_b & ex_m2reg;

    // EX is the younger producer, so it takes priority over MEM
    if (exm_a)      fwda = ex_m2reg ? 2'b00 : 2'b01;
    else if (mmm_a) fwda = mm_m2reg ? 2'b11 : 2'b10;
    else            fwda = 2'b00;

    if (exm_b)      fwdb = ex_m2reg ? 2'b00 : 2'b01;
    else if (mmm_b) fwdb = mm_m2reg ? 2'b11 : 2'b10;
    else            fwdb = 2'b00;

    // A flushed ID instruction is dead, so it cannot cause a stall
    stall  = (haz_a | haz_b) & ~flush;
    wpcir  = ~stall & ~freeze;
    bubble = (stall | flush) & ~freeze;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ex_wreg   <= 1'b0;
      ex_m2reg  <= 1'b0;
      ex_rn     <= '0;
      mm_wreg   <= 1'b0;
      mm_m2reg  <= 1'b0;
      mm_rn     <= '0;
      stall_cnt <= '0;
    end else if (!freeze) begin
      mm_wreg  <= ex_wreg;
      mm_m2reg <= ex_m2reg;
      mm_rn    <= ex_rn;
      if (stall | flush) begin
        ex_wreg  <= 1'b0;
        ex_m2reg <= 1'b0;
        ex_rn    <= '0;
      end else begin
        ex_wreg  <= id_wreg;
        ex_m2reg <= id_m2reg;
        ex_rn    <= id_rn;
      end
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard control unit for the 5-stage MIPS pipeline. Sits in the ID stage.
- Tracks the destination registers of the instructions in EX and MEM in its own shadow pipeline registers.
- Each cycle it produces the 2-bit select codes for the two forwarding multiplexers (operand A and operand B) and the load-use stall / PC-IR write enable.
- Also drives a bubble-insert strobe and maintains a saturating stall-cycle counter for performance debug.

Parameters:
- RA_W, 5, register address width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- clrn  in  1  asynchronous active-low reset
- id_rs  in  RA_W  source register A of the instruction in ID
- id_rt  in  RA_W  source register B of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_wreg  in  1  ID instruction writes the register file
- id_m2reg  in  1  ID instruction is a load (result comes from data memory)
- id_rn  in  RA_W  destination register of the ID instruction
- flush  in  1  branch/jump taken: ID instruction is squashed
- freeze  in  1  global hold (memory not ready); all state holds
- fwda  out  2  operand A forward select
- fwdb  out  2  operand B forward select
- wpcir  out  1  PC/IF-ID write enable (0 = stall)
- bubble  out  1  EX receives a NOP this cycle
- stall_cnt  out  CNT_W  count of load-use stall cycles

Behaviour:
- Forward select encoding:
  - 00: register file read (qa/qb)
  - 01: EX ALU result (r)
  - 10: MEM ALU result (mr)
  - 11: MEM load data (do)
- Shadow state:
  - EX slot: ex_wreg, ex_m2reg, ex_rn.
  - MEM slot: mm_wreg, mm_m2reg, mm_rn.
  - Reset (clrn=0, asynchronous): all slot fields 0 and stall_cnt 0. Outputs then read fwda=fwdb=00, wpcir=1, bubble=0.
- Match rule, evaluated combinationally and independently for A (rs) and B (rt):
  - exm = use & ex_wreg & (ex_rn==src) & (src!=0)
  - mmm = use & mm_wreg & (mm_rn==src) & (src!=0)
  - Register 0 is never forwarded.
- Select priority (EX is younger than MEM, so EX wins):
  - exm & ex_m2reg: load-use hazard; select forced to 00.
  - exm & !ex_m2reg: 01.
  - mmm & mm_m2reg: 11.
  - mmm: 10.
  - otherwise: 00.
- Load-use stall:
  - stall = hazard on A or B, with id_valid implied by !flush.
  - wpcir = !stall & !freeze.
  - bubble = (stall | flush) & !freeze.
- Slot update on rising edge, when freeze=0:
  - MEM slot <= EX slot.
  - EX slot <= ID fields if !(stall|flush). Otherwise EX slot <= zeros (bubble: wreg=0, m2reg=0, rn=0).
- freeze=1: all slots and stall_cnt hold. fwda/fwdb still reflect the current compare; wpcir=0; bubble=0.
- Simultaneous events:
  - flush with stall: flush wins. The ID instruction is killed, so stall is suppressed and wpcir=1.
  - freeze dominates both flush and stall.
- stall_cnt: increments by 1 on each edge where stall & !freeze. It saturates at all-ones and does not wrap.
- Latency:
  - fwda/fwdb/wpcir/bubble are same-cycle combinational functions of the inputs and the slots.
  - A load's result becomes forwardable (11) exactly one cycle after the stall cycle.
- Reset mid-operation clears all in-flight destination info immediately. The first post-reset instruction sees 00 selects.

Test Plan:
- Reset, then ID add with rs=3,rt=4 and empty slots -> fwda=00, fwdb=00, wpcir=1, bubble=0, stall_cnt=0.
- Cycle N: add $5 (wreg=1,rn=5). Cycle N+1: ID sub rs=5,rt=5 -> fwda=01, fwdb=01. Hold sub in ID one more cycle (add now in MEM) -> fwda=10, fwdb=10.
- lw $7 in EX, ID add rs=7 -> wpcir=0, bubble=1, fwda=00, stall_cnt 0->1. Next cycle (lw in MEM, EX bubble) -> fwda=11, wpcir=1, bubble=0.
- EX writes $2 (ALU) and MEM writes $2 (load); ID rs=2 -> fwda=01 (EX priority). ID rs=0 with EX rn=0, wreg=1 -> fwda=00.
- Load-use hazard with flush=1 in the same cycle -> wpcir=1, bubble=1, no stall_cnt increment. The same hazard with freeze=1 -> wpcir=0, bubble=0, slots and counter unchanged over 3 cycles.
- Preload stall_cnt to all-ones-1 via a sustained hazard (CNT_W=4 build: 15 stalls) -> reaches 15 and holds at 15. Assert clrn mid-stall -> outputs at reset values asynchronously.
